// File: rtl/flag_sequencer.sv
// Flag selector sequencer: debounced next/prev buttons plus timed auto-advance
// drive a wrapping flag index with a one-cycle change strobe.

module flag_sequencer_debounce #(
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic clk,
   input  logic reset_i,
   input  logic frame_tick_i,
   input  logic btn_i,
   output logic press_o
);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

   localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

   logic [1:0] sync_q;
   state_e     state_q;
   logic [3:0] cnt_q;
   logic       press_q;

   // sync_q[1] is the only synchronized view of the button used below
   always_ff @(posedge clk) begin
      if (reset_i) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         press_q <= 1'b0;
         if (frame_tick_i) begin
            case (state_q)
               IDLE: if (sync_q[1]) begin
                  if (DEB == 4'd1) begin
                     state_q <= HELD;
                     cnt_q   <= '0;
                     press_q <= 1'b1;
                  end else begin
                     state_q <= PRESS_WAIT;
                     cnt_q   <= 4'd1;
                  end
               end
               PRESS_WAIT: if (!sync_q[1]) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q + 4'd1 == DEB) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
               HELD: if (!sync_q[1]) begin
                  if (DEB == 4'd1) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= RELEASE_WAIT;
                     cnt_q   <= 4'd1;
                  end
               end
               RELEASE_WAIT: if (sync_q[1]) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q + 4'd1 == DEB) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign press_o = press_q;
endmodule

module flag_sequencer #(
   parameter int DEBOUNCE_FRAMES = 2,
   parameter int HOLD_FRAMES     = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       auto_en,
   input  logic [6:0] max,
   output logic [6:0] selector,
   output logic       changed
);
   localparam logic [9:0] HOLD = 10'(HOLD_FRAMES);

   logic       nxt_ev, prv_ev, manual_ev;
   logic       auto_ev_q;
   logic [9:0] auto_cnt_q;
   logic [6:0] sel_q, sel_next, sel_prev;
   logic       chg_q;

   flag_sequencer_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_next (
      .clk(clk), .reset_i(reset), .frame_tick_i(frame_tick), .btn_i(btn_next), .press_o(nxt_ev)
   );
   flag_sequencer_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_prev (
      .clk(clk), .reset_i(reset), .frame_tick_i(frame_tick), .btn_i(btn_prev), .press_o(prv_ev)
   );

   assign manual_ev = nxt_ev | prv_ev;

   always_comb begin
      sel_next = (sel_q >= max) ? 7'd0 : sel_q + 7'd1;
      sel_prev = (sel_q == 7'd0 || sel_q > max) ? max : sel_q - 7'd1;
   end

   // A cancelled next/prev pair still counts as manual: it resets the auto
   // timer and suppresses any auto step landing in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         auto_cnt_q <= '0;
         auto_ev_q  <= 1'b0;
         sel_q      <= '0;
         chg_q      <= 1'b0;
      end else begin
         auto_ev_q <= 1'b0;
         if (!auto_en || manual_ev) begin
            auto_cnt_q <= '0;
         end else if (frame_tick) begin
            if (auto_cnt_q + 10'd1 == HOLD) begin
               auto_cnt_q <= '0;
               auto_ev_q  <= 1'b1;
            end else begin
               auto_cnt_q <= auto_cnt_q + 10'd1;
            end
         end

         chg_q <= 1'b0;
         if (nxt_ev ^ prv_ev) begin
            sel_q <= nxt_ev ? sel_next : sel_prev;
            chg_q <= 1'b1;
         end else if (!manual_ev && auto_ev_q) begin
            sel_q <= sel_next;
            chg_q <= 1'b1;
         end
      end
   end

   assign selector = sel_q;
   assign changed  = chg_q;
endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer: debounce, wrap, cancel, auto-advance and
// reset behaviour, plus a DEBOUNCE_FRAMES=1 instance for the single-frame path.

module tb_flag_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       auto_en = 1'b0;
   logic [6:0] max = 7'd81;
   logic [6:0] selector, selector1;
   logic       changed, changed1;

   int n_chk = 0;
   int n_fail = 0;
   int chg_cnt = 0;
   int exp_chg = 0;

   flag_sequencer #(.DEBOUNCE_FRAMES(2), .HOLD_FRAMES(4)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_next(btn_next),
      .btn_prev(btn_prev), .auto_en(auto_en), .max(max),
      .selector(selector), .changed(changed)
   );

   flag_sequencer #(.DEBOUNCE_FRAMES(1), .HOLD_FRAMES(4)) dut1 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_next(btn_next),
      .btn_prev(btn_prev), .auto_en(auto_en), .max(max),
      .selector(selector1), .changed(changed1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (changed === 1'b1) chg_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      cyc(3);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic press(input bit nxt);
      if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
      cyc(3);
      frames(2);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      cyc(3);
      frames(2);
   endtask

   initial begin
      // reset state
      cyc(3);
      chk("reset_sel", selector, 0);
      chk("reset_chg", changed, 0);
      reset = 1'b0;
      cyc(4);
      chk("reset_exit_nopulse", chg_cnt, exp_chg);

      // next held across 3 frames: one step only
      btn_next = 1'b1;
      cyc(3);
      frame();
      chk("deb_1frame_sel", selector, 0);
      frames(2);
      exp_chg++;
      chk("held_sel", selector, 1);
      chk("held_pulses", chg_cnt, exp_chg);
      btn_next = 1'b0;
      cyc(3);
      frames(2);
      chk("release_sel", selector, 1);
      chk("release_pulses", chg_cnt, exp_chg);

      // wrap both directions
      press(1'b0); exp_chg++;
      chk("prev_1_to_0", selector, 0);
      press(1'b0); exp_chg++;
      chk("prev_0_to_max", selector, 81);
      press(1'b1); exp_chg++;
      chk("next_max_to_0", selector, 0);
      chk("wrap_pulses", chg_cnt, exp_chg);

      // simultaneous presses cancel
      btn_next = 1'b1;
      btn_prev = 1'b1;
      cyc(3);
      frames(2);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      cyc(3);
      frames(2);
      chk("cancel_sel", selector, 0);
      chk("cancel_pulses", chg_cnt, exp_chg);

      // max changes apply only at the next step
      max = 7'd50;
      press(1'b0); exp_chg++;
      chk("prev_to_50", selector, 50);
      max = 7'd20;
      cyc(4);
      chk("max_change_no_effect", selector, 50);
      press(1'b1); exp_chg++;
      chk("next_above_max", selector, 0);
      max = 7'd50;
      press(1'b0); exp_chg++;
      max = 7'd20;
      press(1'b0); exp_chg++;
      chk("prev_above_max", selector, 20);
      chk("max_pulses", chg_cnt, exp_chg);

      // one-frame glitch: ignored with 2-frame debounce, accepted with 1
      max = 7'd81;
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      btn_next = 1'b1;
      cyc(3);
      frame();
      btn_next = 1'b0;
      cyc(3);
      frames(2);
      chk("glitch_sel", selector, 0);
      chk("glitch_pulses", chg_cnt, exp_chg);
      chk("deb1_sel", selector1, 1);

      // auto advance every 4 frames
      auto_en = 1'b1;
      frames(3);
      chk("auto_f3", selector, 0);
      frame(); exp_chg++;
      chk("auto_f4", selector, 1);
      frames(4); exp_chg++;
      chk("auto_f8", selector, 2);
      btn_next = 1'b1;
      cyc(3);
      frames(2); exp_chg++;
      chk("manual_during_auto", selector, 3);
      btn_next = 1'b0;
      cyc(3);
      frames(3);
      chk("auto_restart_f3", selector, 3);
      frame(); exp_chg++;
      chk("auto_restart_f4", selector, 4);

      // manual press coincident with auto step: one step only
      frames(2);
      btn_next = 1'b1;
      cyc(3);
      frames(2); exp_chg++;
      chk("coincident_sel", selector, 5);
      btn_next = 1'b0;
      cyc(3);
      frames(3);
      chk("coincident_after_f3", selector, 5);
      frame(); exp_chg++;
      chk("coincident_after_f4", selector, 6);
      chk("auto_pulses", chg_cnt, exp_chg);

      // auto_en low clears the counter
      frames(2);
      auto_en = 1'b0;
      frame();
      auto_en = 1'b1;
      frames(3);
      chk("auto_en_clear_f3", selector, 6);
      frame(); exp_chg++;
      chk("auto_en_clear_f4", selector, 7);

      // reset mid-debounce with auto counter one short of firing
      frames(2);
      btn_next = 1'b1;
      cyc(3);
      frame();
      reset = 1'b1;
      cyc(2);
      chk("midreset_sel", selector, 0);
      chk("midreset_chg", changed, 0);
      reset = 1'b0;
      cyc(3);
      frame();
      chk("post_reset_f1", selector, 0);
      chk("post_reset_pulses", chg_cnt, exp_chg);
      frame(); exp_chg++;
      chk("post_reset_f2", selector, 1);
      chk("final_pulses", chg_cnt, exp_chg);
      btn_next = 1'b0;
      auto_en = 1'b0;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
